// File: rtl/picosoc_arb_pkg.sv
// Shared definitions for the PicoSoC two-master memory arbiter:
// FSM state encoding and watchdog counter width.
package picosoc_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam int ARB_TCNT_W = 16;

endpackage

// File: rtl/picosoc_arb_timeout.sv
// Stall watchdog for the arbiter: counts cycles the current owner has been
// waiting on the shared bus and flags the cycle on which the limit is hit.
module picosoc_arb_timeout
    import picosoc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam logic [ARB_TCNT_W-1:0] LIMIT = ARB_TCNT_W'(TIMEOUT - 1);

    logic [ARB_TCNT_W-1:0] cnt;

    // Stall counter: zero outside an ownership, advances on every stalled cycle
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = count && (cnt == LIMIT);

endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Round-robin arbiter letting the CPU (master 0) and a second master share
// the PicoRV32 native memory bus. A grant is held until the owner's transfer
// completes or is withdrawn.
// Optional stall watchdog: define PICOSOC_ARB_TIMEOUT_EN to build it.
module picosoc_mem_arbiter
    import picosoc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_irq
);

    arb_state_t  state;
    arb_state_t  state_next;
    arb_state_t  cur;
    logic        rr;
    logic        rr_next;
    logic        owning;
    logic        sel;
    logic        expire;

    logic        owner_valid;
    logic        owner_instr;
    logic [31:0] owner_addr;
    logic [31:0] owner_wdata;
    logic [3:0]  owner_wstrb;
    logic        owner_ready;
    logic [31:0] owner_rdata;

    // While reset is high the outputs behave as if idle, so a slave access
    // that is being abandoned can never complete toward a master.
    assign cur    = reset ? ARB_IDLE : state;
    assign owning = (cur == ARB_OWN0) || (cur == ARB_OWN1);
    assign sel    = (cur == ARB_OWN1);

    assign owner_valid = sel ? m1_valid : m0_valid;
    assign owner_instr = sel ? m1_instr : m0_instr;
    assign owner_addr  = sel ? m1_addr  : m0_addr;
    assign owner_wdata = sel ? m1_wdata : m0_wdata;
    assign owner_wstrb = sel ? m1_wstrb : m0_wstrb;

`ifdef PICOSOC_ARB_TIMEOUT_EN
    picosoc_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!owning),
        .count  (owning && !s_ready),
        .expire (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^(32'(TIMEOUT));
    assign expire         = 1'b0;
`endif

    // State register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            rr    <= 1'b0;
        end else begin
            state <= state_next;
            rr    <= rr_next;
        end
    end

    // Next-state selection and bus routing for the current owner
    always_comb begin
        state_next  = cur;
        rr_next     = rr;
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        grant       = 2'b00;
        timeout_irq = 1'b0;
        owner_ready = 1'b0;
        owner_rdata = '0;

        case (cur)
            ARB_IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_next = rr ? ARB_OWN1 : ARB_OWN0;
                end else if (m0_valid) begin
                    state_next = ARB_OWN0;
                end else if (m1_valid) begin
                    state_next = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                grant       = sel ? 2'b10 : 2'b01;
                s_valid     = owner_valid;
                s_instr     = owner_instr;
                s_addr      = owner_addr;
                s_wdata     = owner_wdata;
                s_wstrb     = owner_wstrb;
                owner_ready = s_ready;
                owner_rdata = s_rdata;
                if (owner_valid && s_ready) begin
                    state_next = ARB_IDLE;
                    rr_next    = !sel;
                end else if (!owner_valid) begin
                    state_next = ARB_IDLE;
                end else if (expire) begin
                    s_valid     = 1'b0;
                    owner_ready = 1'b1;
                    owner_rdata = ERR_RDATA;
                    timeout_irq = 1'b1;
                    state_next  = ARB_IDLE;
                    rr_next     = !sel;
                end
                if (sel) begin
                    m1_ready = owner_ready;
                    m1_rdata = owner_rdata;
                end else begin
                    m0_ready = owner_ready;
                    m0_rdata = owner_rdata;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Testbench for picosoc_mem_arbiter: directed vectors, a transaction-level
// reference model compared on every cycle, and hand-computed expectations.
// Watchdog scenarios run when PICOSOC_ARB_TIMEOUT_EN is defined.
module tb_picosoc_mem_arbiter;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef PICOSOC_ARB_TIMEOUT_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mv[2];
    logic        mi[2];
    logic [31:0] ma[2];
    logic [31:0] mw[2];
    logic [3:0]  ms[2];
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m1_ready, s_valid, s_instr, timeout_irq;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    // Model state: who owns the bus (-1 none), which master is favoured on a
    // tie, and how many stalled cycles the current owner has seen.
    int owner  = -1;
    bit fav    = 1'b0;
    int waited = 0;

    always #5 clk = ~clk;

    picosoc_mem_arbiter #(
        .TIMEOUT   (TO),
        .ERR_RDATA (ERR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_valid    (mv[0]),
        .m0_instr    (mi[0]),
        .m0_addr     (ma[0]),
        .m0_wdata    (mw[0]),
        .m0_wstrb    (ms[0]),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (mv[1]),
        .m1_instr    (mi[1]),
        .m1_addr     (ma[1]),
        .m1_wdata    (mw[1]),
        .m1_wstrb    (ms[1]),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_instr     (s_instr),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .timeout_irq (timeout_irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v0, input logic v1,
                                 input logic rdy, input logic [31:0] rdata);
        reset   = rst;
        mv[0]   = v0;
        mv[1]   = v1;
        s_ready = rdy;
        s_rdata = rdata;
    endtask

    task automatic setReq(input int i, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
        mi[i] = instr;
        ma[i] = addr;
        mw[i] = wdata;
        ms[i] = wstrb;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // The owner's watchdog fires when it has stalled TO-1 cycles already and
    // is still stalled with its request up.
    function automatic bit mdl_timeout();
        if (reset || owner < 0) return 1'b0;
        return WDOG && mv[owner] && !s_ready && (waited == int'(TO) - 1);
    endfunction

    // Model: advance ownership at each clock edge
    always @(posedge clk) begin
        if (reset) begin
            owner  <= -1;
            fav    <= 1'b0;
            waited <= 0;
        end else if (owner < 0) begin
            if (mv[0] && mv[1]) owner <= fav ? 1 : 0;
            else if (mv[0])     owner <= 0;
            else if (mv[1])     owner <= 1;
            waited <= 0;
        end else if (mv[owner] && s_ready) begin
            fav   <= (owner == 0);
            owner <= -1;
        end else if (!mv[owner]) begin
            owner <= -1;
        end else if (mdl_timeout()) begin
            fav   <= (owner == 0);
            owner <= -1;
        end else begin
            waited <= waited + 1;
        end
    end

    // Compare every DUT output against the model in mid-cycle
    always @(negedge clk) begin : cmp
        logic        e_sv, e_instr, e_irq;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_grant;
        logic        e_ready[2];
        logic [31:0] e_rdata[2];
        e_sv = 1'b0; e_instr = 1'b0; e_irq = 1'b0;
        e_addr = '0; e_wdata = '0; e_wstrb = '0; e_grant = 2'b00;
        e_ready[0] = 1'b0; e_ready[1] = 1'b0;
        e_rdata[0] = '0;   e_rdata[1] = '0;
        if (!reset && owner >= 0) begin
            e_grant = (owner == 0) ? 2'b01 : 2'b10;
            e_instr = mi[owner];
            e_addr  = ma[owner];
            e_wdata = mw[owner];
            e_wstrb = ms[owner];
            if (mdl_timeout()) begin
                e_ready[owner] = 1'b1;
                e_rdata[owner] = ERR;
                e_irq          = 1'b1;
            end else begin
                e_sv           = mv[owner];
                e_ready[owner] = s_ready;
                e_rdata[owner] = s_rdata;
            end
        end
        checkOutput("mdl.s_valid",     s_valid,     e_sv);
        checkOutput("mdl.s_instr",     s_instr,     e_instr);
        checkOutput("mdl.s_addr",      s_addr,      e_addr);
        checkOutput("mdl.s_wdata",     s_wdata,     e_wdata);
        checkOutput("mdl.s_wstrb",     s_wstrb,     e_wstrb);
        checkOutput("mdl.grant",       grant,       e_grant);
        checkOutput("mdl.m0_ready",    m0_ready,    e_ready[0]);
        checkOutput("mdl.m1_ready",    m1_ready,    e_ready[1]);
        checkOutput("mdl.m0_rdata",    m0_rdata,    e_rdata[0]);
        checkOutput("mdl.m1_rdata",    m1_rdata,    e_rdata[1]);
        checkOutput("mdl.timeout_irq", timeout_irq, e_irq);
    end

    // Directed scenarios with hand-computed expectations
    initial begin
        logic [1:0] glog[4];
        logic [1:0] rlog[4];
        logic [1:0] exp_g[4];
        logic [1:0] got;
        logic [1:0] served[$];

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        setReq(0, 1'b0, 32'h0, 32'h0, 4'h0);
        setReq(1, 1'b0, 32'h0, 32'h0, 4'h0);
        $display("[TB] starting picosoc_mem_arbiter bench");
        nextCycle();
        nextCycle();

        // Reset values
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        checkOutput("rst.s_valid",  s_valid,     1'b0);
        checkOutput("rst.m0_ready", m0_ready,    1'b0);
        checkOutput("rst.m1_ready", m1_ready,    1'b0);
        checkOutput("rst.grant",    grant,       2'b00);
        checkOutput("rst.irq",      timeout_irq, 1'b0);
        checkOutput("rst.s_addr",   s_addr,      32'h0);

        // Single m0 read, slave ready on the 2nd s_valid cycle
        nextCycle();
        setReq(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        checkOutput("single.idle_grant", grant, 2'b00);
        nextCycle();
        settle();
        checkOutput("single.grant",    grant,    2'b01);
        checkOutput("single.s_valid",  s_valid,  1'b1);
        checkOutput("single.s_addr",   s_addr,   32'h0000_0010);
        checkOutput("single.wait_rdy", m0_ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        settle();
        checkOutput("single.m0_ready", m0_ready, 1'b1);
        checkOutput("single.m0_rdata", m0_rdata, 32'h1234_5678);
        checkOutput("single.m1_ready", m1_ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        checkOutput("single.after_grant", grant,    2'b00);
        checkOutput("single.after_rdy",   m0_ready, 1'b0);

        // Contention right after reset: m0, one idle cycle, then m1
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        setReq(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        setReq(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_2222);
        for (int k = 0; k < 4; k++) begin
            settle();
            glog[k] = grant;
            rlog[k] = {m1_ready, m0_ready};
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10};
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("contend.grant%0d", k), glog[k], exp_g[k]);
            checkOutput($sformatf("contend.ready%0d", k), rlog[k], exp_g[k]);
        end

        // Fairness: both request continuously, always-ready slave
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE_0000);
        for (int c = 0; c < 16; c++) begin
            settle();
            if (s_valid && s_ready) served.push_back(grant);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("fair.count", served.size(), 8);
        for (int i = 0; i < 8; i++) begin
            got = (i < served.size()) ? served[i] : 2'b00;
            checkOutput($sformatf("fair.turn%0d", i), got, (i % 2 == 0) ? 2'b01 : 2'b10);
        end

        // Write forwarding from m1; m0 carries a different idle request
        nextCycle();
        setReq(0, 1'b1, 32'hFFFF_0000, 32'h0000_0001, 4'hF);
        setReq(1, 1'b0, 32'h0200_0008, 32'hA5A5_A5A5, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        settle();
        checkOutput("wr.grant",    grant,    2'b10);
        checkOutput("wr.s_valid",  s_valid,  1'b1);
        checkOutput("wr.s_addr",   s_addr,   32'h0200_0008);
        checkOutput("wr.s_wdata",  s_wdata,  32'hA5A5_A5A5);
        checkOutput("wr.s_wstrb",  s_wstrb,  4'b0001);
        checkOutput("wr.m0_ready", m0_ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        settle();
        checkOutput("wr.m1_ready",  m1_ready, 1'b1);
        checkOutput("wr.m0_ready2", m0_ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the 3rd OWN1 cycle after an m0 completion moved rr to m1
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        settle();
        checkOutput("rstmid.own1", grant, 2'b10);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_5555);
        settle();
        checkOutput("rstmid.s_valid",  s_valid,  1'b0);
        checkOutput("rstmid.m1_ready", m1_ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        settle();
        checkOutput("rstmid.idle_grant", grant, 2'b00);
        nextCycle();
        settle();
        checkOutput("rstmid.m0_wins", grant, 2'b01);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();

`ifdef PICOSOC_ARB_TIMEOUT_EN
        // Watchdog: stalled slave, termination on the 4th OWN0 cycle
        setReq(0, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            settle();
            if (k < 4) begin
                checkOutput($sformatf("wdog.irq%0d", k), timeout_irq, 1'b0);
                checkOutput($sformatf("wdog.rdy%0d", k), m0_ready,    1'b0);
            end
        end
        checkOutput("wdog.m0_ready", m0_ready,    1'b1);
        checkOutput("wdog.m0_rdata", m0_rdata,    32'hDEAD_BEEF);
        checkOutput("wdog.irq",      timeout_irq, 1'b1);
        checkOutput("wdog.s_valid",  s_valid,     1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        checkOutput("wdog.after_grant", grant,       2'b00);
        checkOutput("wdog.after_irq",   timeout_irq, 1'b0);

        // Watchdog race: slave completes on the limit cycle
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 3; k++) nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D);
        settle();
        checkOutput("race.m0_ready", m0_ready,    1'b1);
        checkOutput("race.m0_rdata", m0_rdata,    32'h0BAD_F00D);
        checkOutput("race.irq",      timeout_irq, 1'b0);
        checkOutput("race.s_valid",  s_valid,     1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`else
        // No watchdog: a stalled owner keeps the bus and no irq appears
        setReq(0, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 12; k++) nextCycle();
        settle();
        checkOutput("nowdog.grant",   grant,       2'b01);
        checkOutput("nowdog.irq",     timeout_irq, 1'b0);
        checkOutput("nowdog.s_valid", s_valid,     1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`endif

        nextCycle();
        nextCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
